morse_key_decoder: RTL and testbench
====================================

Name: morse_key_decoder

Overview:
- Receives a single hand-keyed Morse line (button or telegraph key, high = key down) and measures mark and space durations in clock cycles.
- Classifies each mark as a dot or a dash and assembles up to 5 elements per character.
- At an inter-character gap, emits the ASCII code (lowercase a–z, digits 0–9). At an inter-word gap, emits an ASCII space.
- Sits between the board key input and the UART/text path of the morse-blinker design. It is the receive-side counterpart of the ASCII-to-Morse pattern path and uses the same 5-bit pattern / 3-bit length format.

Parameters:
- CLKS_PER_UNIT, 2500000, clocks per Morse time unit (dot length); must be ≥ 2.

Ports:
- i_Clk  in  1  system clock
- i_Rst_n  in  1  asynchronous active-low reset
- i_Key  in  1  raw key level (1 = key down), asynchronous to i_Clk
- o_ASCII  out  8  decoded character; held until the next emission
- o_Valid  out  1  one-clock pulse; o_ASCII, o_Morse_Pattern and o_Morse_Length are valid this cycle
- o_Error  out  1  one-clock pulse; the character just ended was undecodable or longer than 5 elements
- o_Morse_Pattern  out  5  received elements, MSB-first (bit4 = first element), 1 = dash, 0 = dot, unused LSBs 0
- o_Morse_Length  out  3  element count 1–5; 0 for a space
- o_Busy  out  1  1 whenever the state is not IDLE

Behaviour:
- Reset is asynchronous and active-low. All outputs go to 0, the state goes to IDLE, and the synchronizer flops, counter, pattern, length and overflow flag are cleared. A partial character is discarded with no pulse.
- i_Key passes through a 2-flop synchronizer to produce key_s, giving 2 clocks of latency. No debounce.
- A single duration counter clears on every key_s edge and saturates at 5*CLKS_PER_UNIT; it never wraps.
- Thresholds:
  - DASH_CLKS = 2*CLKS_PER_UNIT
  - CHAR_CLKS = 2*CLKS_PER_UNIT
  - WORD_CLKS = 5*CLKS_PER_UNIT
- States: IDLE, MARK, SPACE, WORD_WAIT.
- IDLE:
  - key_s = 1 → MARK.
  - No output activity. A long silence after reset does not emit a space.
- MARK (key_s = 1), on key_s falling:
  - Let L = number of clocks key_s was 1. The element is a dash iff L ≥ DASH_CLKS, otherwise a dot.
  - If length < 5: pattern[4-length] = element and length++. If length = 5: set overflow and leave the pattern unchanged.
  - → SPACE.
  - A key held indefinitely saturates the counter and classifies as a dash.
- SPACE (key_s = 0):
  - key_s rises before key_s has been 0 for CHAR_CLKS consecutive clocks → MARK, same character.
  - key_s has been 0 for exactly CHAR_CLKS consecutive clocks → on the next clock, emit the character, clear pattern/length/overflow, → WORD_WAIT.
- Character emission:
  - Overflow set, or pattern/length not a valid International Morse lowercase letter or digit → o_Error = 1 for one clock. o_Valid stays 0 and o_ASCII is unchanged.
  - Otherwise o_Valid = 1 for one clock with o_ASCII, o_Morse_Pattern and o_Morse_Length registered.
  - Unused pattern bits must be 0 for a match.
- WORD_WAIT:
  - The counter keeps counting from the end of the last mark.
  - key_s rises first → MARK; no space is emitted.
  - key_s has been 0 for WORD_CLKS consecutive clocks → on the next clock, o_Valid pulses with o_ASCII = 8'h20, pattern 0, length 0, → IDLE.
  - At most one space is emitted per gap.
- o_Valid and o_Error are never asserted in the same cycle.
- o_Busy = (state != IDLE).
- Key high at reset release: the synchronizer presents 1 after 2 clocks and the block enters MARK normally.

Test Plan:
All scenarios use CLKS_PER_UNIT = 4 (dot = 4 clocks, dash = 12 clocks, intra-character gap = 4 clocks).
- 'a': drive dot, gap, dash, then hold low → 9th clock after the final key_s fall: o_Valid = 1, o_ASCII = 8'h61, pattern 5'b01000, length 2. Continue low → clock 21: o_Valid = 1, o_ASCII = 8'h20, length 0. o_Busy = 0 afterwards, and no further pulses after 100 more low clocks.
- '0' then '5': five dashes, gap ≥ 8, then five dots → o_ASCII 8'h30 (pattern 11111, length 5), then 8'h35 (pattern 00000, length 5). No space between them if the gap is < 20.
- Thresholds: mark of 7 clocks → dot, 8 clocks → dash ('e' vs 't' = 8'h65 / 8'h74). Gap of 7 clocks keeps one character, 8 clocks splits it (dot-gap7-dot → 'i' 8'h69; dot-gap8-dot → two 'e').
- Errors: six dots → o_Error pulse, o_Valid = 0, o_ASCII holds its previous value. Pattern dot-dot-dash-dash (00110, length 4) → o_Error pulse. Next valid character decodes correctly.
- Reset mid-character: two dots, then pull i_Rst_n low for 3 clocks mid-gap → all outputs 0 immediately. After release, 40 low clocks → no o_Valid and no o_Error.
- Stuck key: hold i_Key high for 1000 clocks then release → counter does not wrap, the element is a dash, 't' is emitted.

Source files
------------

// File: rtl/morse_key_decoder.sv
// Hand-keyed Morse receiver: times marks and spaces on a synchronized key line,
// assembles dot/dash patterns and emits lowercase ASCII letters, digits and word spaces.
module morse_key_decoder #(
  parameter int CLKS_PER_UNIT = 2500000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Key,
  output logic [7:0] o_ASCII,
  output logic       o_Valid,
  output logic       o_Error,
  output logic [4:0] o_Morse_Pattern,
  output logic [2:0] o_Morse_Length,
  output logic       o_Busy
);

  localparam int DASH_CLKS = 2 * CLKS_PER_UNIT;
  localparam int CHAR_CLKS = 2 * CLKS_PER_UNIT;
  localparam int WORD_CLKS = 5 * CLKS_PER_UNIT;
  localparam int CW        = $clog2(WORD_CLKS + 1);

  localparam logic [CW-1:0] DASH_C = CW'(DASH_CLKS);
  localparam logic [CW-1:0] CHAR_C = CW'(CHAR_CLKS);
  localparam logic [CW-1:0] WORD_C = CW'(WORD_CLKS);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, WORD_WAIT} state_t;

  state_t        state;
  logic          key_meta;
  logic          key_s;
  logic          key_prev;
  logic [CW-1:0] cnt;
  logic [4:0]    pattern;
  logic [2:0]    length;
  logic          overflow;
  logic [7:0]    decoded;

  function automatic logic [7:0] decode(input logic [2:0] len, input logic [4:0] pat);
    logic [7:0] d;
    d = 8'h00;
    case ({len, pat})
      {3'd2, 5'b01000}: d = 8'h61;  // a
      {3'd4, 5'b10000}: d = 8'h62;
      {3'd4, 5'b10100}: d = 8'h63;
      {3'd3, 5'b10000}: d = 8'h64;
      {3'd1, 5'b00000}: d = 8'h65;
      {3'd4, 5'b00100}: d = 8'h66;
      {3'd3, 5'b11000}: d = 8'h67;
      {3'd4, 5'b00000}: d = 8'h68;
      {3'd2, 5'b00000}: d = 8'h69;
      {3'd4, 5'b01110}: d = 8'h6a;
      {3'd3, 5'b10100}: d = 8'h6b;
      {3'd4, 5'b01000}: d = 8'h6c;
      {3'd2, 5'b11000}: d = 8'h6d;
      {3'd2, 5'b10000}: d = 8'h6e;
      {3'd3, 5'b11100}: d = 8'h6f;
      {3'd4, 5'b01100}: d = 8'h70;
      {3'd4, 5'b11010}: d = 8'h71;
      {3'd3, 5'b01000}: d = 8'h72;
      {3'd3, 5'b00000}: d = 8'h73;
      {3'd1, 5'b10000}: d = 8'h74;
      {3'd3, 5'b00100}: d = 8'h75;
      {3'd4, 5'b00010}: d = 8'h76;
      {3'd3, 5'b01100}: d = 8'h77;
      {3'd4, 5'b10010}: d = 8'h78;
      {3'd4, 5'b10110}: d = 8'h79;
      {3'd4, 5'b11000}: d = 8'h7a;
      {3'd5, 5'b11111}: d = 8'h30;  // 0
      {3'd5, 5'b01111}: d = 8'h31;
      {3'd5, 5'b00111}: d = 8'h32;
      {3'd5, 5'b00011}: d = 8'h33;
      {3'd5, 5'b00001}: d = 8'h34;
      {3'd5, 5'b00000}: d = 8'h35;
      {3'd5, 5'b10000}: d = 8'h36;
      {3'd5, 5'b11000}: d = 8'h37;
      {3'd5, 5'b11100}: d = 8'h38;
      {3'd5, 5'b11110}: d = 8'h39;
      default:          d = 8'h00;
    endcase
    return d;
  endfunction

  assign decoded = decode(length, pattern);

  // cnt = clocks key_s has held its current level, as of the previous sample
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      key_meta <= 1'b0;
      key_s    <= 1'b0;
      key_prev <= 1'b0;
      cnt      <= '0;
    end else begin
      key_meta <= i_Key;
      key_s    <= key_meta;
      key_prev <= key_s;
      if (key_s != key_prev) cnt <= CW'(1);
      else if (cnt != WORD_C) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state           <= IDLE;
      pattern         <= '0;
      length          <= '0;
      overflow        <= 1'b0;
      o_ASCII         <= '0;
      o_Valid         <= 1'b0;
      o_Error         <= 1'b0;
      o_Morse_Pattern <= '0;
      o_Morse_Length  <= '0;
      o_Busy          <= 1'b0;
    end else begin
      o_Valid <= 1'b0;
      o_Error <= 1'b0;
      case (state)
        IDLE: begin
          if (key_s) begin
            state  <= MARK;
            o_Busy <= 1'b1;
          end
        end
        MARK: begin
          if (!key_s) begin
            if (length == 3'd5) begin
              overflow <= 1'b1;
            end else begin
              pattern[3'd4 - length] <= (cnt >= DASH_C);
              length                 <= length + 3'd1;
            end
            state <= SPACE;
          end
        end
        SPACE: begin
          // A gap that just reached the threshold ends the character even if the key rises now
          if (cnt == CHAR_C) begin
            if (overflow || decoded == 8'h00) begin
              o_Error <= 1'b1;
            end else begin
              o_Valid         <= 1'b1;
              o_ASCII         <= decoded;
              o_Morse_Pattern <= pattern;
              o_Morse_Length  <= length;
            end
            pattern  <= '0;
            length   <= '0;
            overflow <= 1'b0;
            state    <= key_s ? MARK : WORD_WAIT;
          end else if (key_s) begin
            state <= MARK;
          end
        end
        WORD_WAIT: begin
          if (cnt >= WORD_C) begin
            o_Valid         <= 1'b1;
            o_ASCII         <= 8'h20;
            o_Morse_Pattern <= '0;
            o_Morse_Length  <= '0;
            state           <= key_s ? MARK : IDLE;
            o_Busy          <= key_s;
          end else if (key_s) begin
            state <= MARK;
          end
        end
        default: begin
          state  <= IDLE;
          o_Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_key_decoder.sv
// Directed bench for morse_key_decoder with CLKS_PER_UNIT = 4; every emission is
// captured into an event queue and compared against hand-computed expectations.
module tb_morse_key_decoder;

  logic       clk;
  logic       rst_n;
  logic       key;
  logic [7:0] ascii;
  logic       valid;
  logic       error;
  logic [4:0] mpat;
  logic [2:0] mlen;
  logic       busy;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc     = 0;
  int both    = 0;

  typedef struct {
    bit         v;
    bit         e;
    logic [7:0] a;
    logic [4:0] p;
    logic [2:0] l;
    int         t;
  } ev_t;

  ev_t evq[$];

  morse_key_decoder #(.CLKS_PER_UNIT(4)) dut (
    .i_Clk           (clk),
    .i_Rst_n         (rst_n),
    .i_Key           (key),
    .o_ASCII         (ascii),
    .o_Valid         (valid),
    .o_Error         (error),
    .o_Morse_Pattern (mpat),
    .o_Morse_Length  (mlen),
    .o_Busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid || error) begin
      evq.push_back('{valid, error, ascii, mpat, mlen, cyc});
      $display("event cyc=%0d valid=%0b error=%0b ascii=%02h pattern=%05b length=%0d",
               cyc, valid, error, ascii, mpat, mlen);
    end
    if (valid && error) both++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    key = lvl;
    repeat (n) @(negedge clk);
  endtask

  // one element followed by a low gap
  task automatic elem(input bit dash, input int gap);
    hold(1'b1, dash ? 12 : 4);
    hold(1'b0, gap);
  endtask

  task automatic expect_ev(input string tag, input int idx, input bit v, input bit e,
                           input logic [7:0] a, input logic [4:0] p, input logic [2:0] l);
    if (idx < evq.size()) begin
      check({tag, "_kind"},  {30'd0, evq[idx].v, evq[idx].e}, {30'd0, v, e});
      check({tag, "_ascii"}, {24'd0, evq[idx].a}, {24'd0, a});
      if (v) begin
        check({tag, "_pat"}, {27'd0, evq[idx].p}, {27'd0, p});
        check({tag, "_len"}, {29'd0, evq[idx].l}, {29'd0, l});
      end
    end else begin
      check({tag, "_present"}, evq.size(), idx + 1);
    end
  endtask

  int rel;

  initial begin
    rst_n = 1'b0;
    key   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ascii", {24'd0, ascii}, 0);
    check("rst_valid", {31'd0, valid}, 0);
    check("rst_error", {31'd0, error}, 0);
    check("rst_pat",   {27'd0, mpat},  0);
    check("rst_len",   {29'd0, mlen},  0);
    check("rst_busy",  {31'd0, busy},  0);
    rst_n = 1'b1;
    hold(1'b0, 10);

    // 'a' with exact emission timing, then word space, then long silence
    evq.delete();
    hold(1'b1, 4);
    check("a_busy_mark", {31'd0, busy}, 1);
    hold(1'b0, 4);
    hold(1'b1, 12);
    rel = cyc;
    hold(1'b0, 130);
    check("a_count", evq.size(), 2);
    expect_ev("a_chr", 0, 1, 0, 8'h61, 5'b01000, 3'd2);
    if (evq.size() > 0) check("a_time", evq[0].t, rel + 11);
    expect_ev("a_spc", 1, 1, 0, 8'h20, 5'b00000, 3'd0);
    if (evq.size() > 1) check("a_spc_time", evq[1].t, rel + 23);
    check("a_busy_end", {31'd0, busy}, 0);

    // '0' then '5' with a gap shorter than a word gap
    evq.delete();
    for (int i = 0; i < 5; i++) elem(1'b1, (i == 4) ? 10 : 4);
    for (int i = 0; i < 5; i++) elem(1'b0, (i == 4) ? 30 : 4);
    check("d05_count", evq.size(), 3);
    expect_ev("d0", 0, 1, 0, 8'h30, 5'b11111, 3'd5);
    expect_ev("d5", 1, 1, 0, 8'h35, 5'b00000, 3'd5);
    expect_ev("d05_spc", 2, 1, 0, 8'h20, 5'b00000, 3'd0);

    // mark threshold: 7 clocks dot, 8 clocks dash
    evq.delete();
    hold(1'b1, 7);
    hold(1'b0, 30);
    hold(1'b1, 8);
    hold(1'b0, 30);
    check("thr_mark_count", evq.size(), 4);
    expect_ev("thr_e", 0, 1, 0, 8'h65, 5'b00000, 3'd1);
    expect_ev("thr_t", 2, 1, 0, 8'h74, 5'b10000, 3'd1);

    // gap threshold: 7 keeps one character, 8 splits it
    evq.delete();
    elem(1'b0, 7);
    elem(1'b0, 30);
    check("gap7_count", evq.size(), 2);
    expect_ev("gap7_i", 0, 1, 0, 8'h69, 5'b00000, 3'd2);
    evq.delete();
    elem(1'b0, 8);
    elem(1'b0, 30);
    check("gap8_count", evq.size(), 3);
    expect_ev("gap8_e1", 0, 1, 0, 8'h65, 5'b00000, 3'd1);
    expect_ev("gap8_e2", 1, 1, 0, 8'h65, 5'b00000, 3'd1);

    // errors: overflow and an unassigned pattern, then recovery
    evq.delete();
    elem(1'b0, 10);
    for (int i = 0; i < 6; i++) elem(1'b0, (i == 5) ? 30 : 4);
    elem(1'b0, 4);
    elem(1'b0, 4);
    elem(1'b1, 4);
    elem(1'b1, 30);
    elem(1'b1, 4);
    elem(1'b0, 4);
    elem(1'b1, 30);
    check("err_count", evq.size(), 7);
    expect_ev("err_pre_e", 0, 1, 0, 8'h65, 5'b00000, 3'd1);
    expect_ev("err_ovf",   1, 0, 1, 8'h65, 5'b00000, 3'd0);
    expect_ev("err_bad",   3, 0, 1, 8'h20, 5'b00000, 3'd0);
    expect_ev("err_k",     5, 1, 0, 8'h6b, 5'b10100, 3'd3);

    // asynchronous reset in the middle of a character
    evq.delete();
    elem(1'b0, 4);
    hold(1'b1, 4);
    hold(1'b0, 3);
    check("rstmid_busy_before", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid_ascii", {24'd0, ascii}, 0);
    check("rstmid_busy",  {31'd0, busy},  0);
    check("rstmid_pat",   {27'd0, mpat},  0);
    check("rstmid_len",   {29'd0, mlen},  0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold(1'b0, 40);
    check("rstmid_quiet", evq.size(), 0);

    // stuck key saturates into a dash
    evq.delete();
    hold(1'b1, 1000);
    hold(1'b0, 30);
    check("stuck_count", evq.size(), 2);
    expect_ev("stuck_t", 0, 1, 0, 8'h74, 5'b10000, 3'd1);

    check("valid_err_excl", both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
